// File: rtl/jt49_pkg.sv
// Shared definitions for the JT49 envelope control slice: register
// addresses and the 4-bit envelope shape layout.
package jt49_pkg;

    localparam logic [3:0] JT49_R_ENVL  = 4'hB;
    localparam logic [3:0] JT49_R_ENVH  = 4'hC;
    localparam logic [3:0] JT49_R_ENVSH = 4'hD;

    typedef struct packed {
        logic cont;
        logic att;
        logic alt;
        logic hold;
    } jt49_shape_t;

endpackage

// File: rtl/jt49_eg_div.sv
// Envelope step divider: a cen prescaler feeding a period counter that
// emits a one-clk step pulse, always coincident with a cen cycle.
module jt49_eg_div #(
    parameter int PRESCALE = 16,
    parameter int PW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          clr,
    input  logic [PW-1:0] period,
    output logic          step
);

    localparam int             PSW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    logic [PSW-1:0] psc;
    logic [PW-1:0]  cnt;
    logic [PW-1:0]  last;
    logic           tick;
    logic           wrap;

    // A zero period behaves as one; a count already past the period fires at once.
    always_comb begin
        last = (period == '0) ? '0 : period - 1'b1;
        tick = cen && (psc == PS_LAST);
        wrap = (cnt >= last);
        step = rst_n && tick && wrap && !clr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            psc <= '0;
            cnt <= '0;
        end else if (clr) begin
            psc <= '0;
            cnt <= '0;
        end else if (tick) begin
            psc <= '0;
            cnt <= wrap ? '0 : cnt + 1'b1;
        end else if (cen) begin
            psc <= psc + 1'b1;
        end
    end

endmodule

// File: rtl/jt49_eg_ctl.sv
// Envelope control: decodes R11/R12/R13 writes, keeps the restart flag and
// drives the step divider. Define JT49_EG_READBACK_EN to add the dout port.
module jt49_eg_ctl
    import jt49_pkg::*;
#(
    parameter int PRESCALE = 16,
    parameter int PW       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          we,
    input  logic [3:0]    addr,
    input  logic [7:0]    din,
    output logic [3:0]    ctrl,
    output logic          restart,
    output logic          eg_cen,
    output logic [PW-1:0] period
`ifdef JT49_EG_READBACK_EN
    ,
    output logic [7:0]    dout
`endif
);

    logic [15:0] per_q;
    jt49_shape_t shape_q;
    logic        restart_q;
    logic        wr_shape;

    assign wr_shape = we && (addr == JT49_R_ENVSH);
    assign period   = PW'(per_q);
    assign ctrl     = shape_q;
    assign restart  = restart_q;

    // A shape write re-arms restart even if a step is consumed in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_q     <= '0;
            shape_q   <= '0;
            restart_q <= 1'b0;
        end else begin
            if (we && (addr == JT49_R_ENVL)) per_q[7:0]  <= din;
            if (we && (addr == JT49_R_ENVH)) per_q[15:8] <= din;
            if (wr_shape) begin
                shape_q   <= din[3:0];
                restart_q <= 1'b1;
            end else if (eg_cen) begin
                restart_q <= 1'b0;
            end
        end
    end

    jt49_eg_div #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) u_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .clr    (wr_shape),
        .period (period),
        .step   (eg_cen)
    );

`ifdef JT49_EG_READBACK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= 8'h00;
        end else begin
            case (addr)
                JT49_R_ENVL:  dout <= per_q[7:0];
                JT49_R_ENVH:  dout <= per_q[15:8];
                JT49_R_ENVSH: dout <= {4'b0000, shape_q};
                default:      dout <= 8'h00;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_jt49_eg_ctl.sv
// Bench for jt49_eg_ctl: register write table, step timing sequences and a
// randomized run, all checked cycle by cycle against an arithmetic model.
module tb_jt49_eg_ctl;
    import jt49_pkg::*;

    localparam int PRESCALE = 16;
    localparam int PW       = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cen   = 1'b0;
    logic          we    = 1'b0;
    logic [3:0]    addr  = 4'h0;
    logic [7:0]    din   = 8'h00;
    logic [3:0]    ctrl;
    logic          restart;
    logic          eg_cen;
    logic [PW-1:0] period;
`ifdef JT49_EG_READBACK_EN
    logic [7:0]    dout;
`endif

    jt49_eg_ctl #(
        .PRESCALE (PRESCALE),
        .PW       (PW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (cen),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .ctrl    (ctrl),
        .restart (restart),
        .eg_cen  (eg_cen),
        .period  (period)
`ifdef JT49_EG_READBACK_EN
        ,
        .dout    (dout)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: cen ticks within the current period count, and
    // completed period counts since the last step or shape write.
    int          m_psc     = 0;
    int          m_steps   = 0;
    logic [15:0] m_period  = 16'h0000;
    logic [3:0]  m_ctrl    = 4'h0;
    bit          m_restart = 1'b0;
    logic [7:0]  m_dout    = 8'h00;
    bit          last_eg   = 1'b0;

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [7:0]  din;
        logic [3:0]  ctrl;
        logic [15:0] period;
        bit          restart;
    } vec_t;

    vec_t vecs[9];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit predict_fire(bit r, bit c, bit w, logic [3:0] a);
        int eff;
        eff = (m_period == 16'h0000) ? 1 : int'(m_period);
        return r && c && (m_psc == PRESCALE - 1) && (m_steps + 1 >= eff)
               && !(w && a == JT49_R_ENVSH);
    endfunction

    task automatic apply_stimulus(input bit r, input bit c, input bit w,
                                  input logic [3:0] a, input logic [7:0] d);
        bit fire;
        rst_n = r; cen = c; we = w; addr = a; din = d;
        #3;
        fire = predict_fire(r, c, w, a);
        check_output("eg_cen", {31'b0, eg_cen}, {31'b0, fire});
        last_eg = eg_cen;
        @(posedge clk);
        if (!r) begin
            m_psc = 0; m_steps = 0; m_period = '0; m_ctrl = '0;
            m_restart = 1'b0; m_dout = '0;
        end else begin
            case (a)
                JT49_R_ENVL:  m_dout = m_period[7:0];
                JT49_R_ENVH:  m_dout = m_period[15:8];
                JT49_R_ENVSH: m_dout = {4'b0000, m_ctrl};
                default:      m_dout = 8'h00;
            endcase
            if (c) begin
                if (m_psc == PRESCALE - 1) begin
                    m_psc = 0;
                    if (fire) m_steps = 0;
                    else      m_steps++;
                end else begin
                    m_psc++;
                end
            end
            if (w && a == JT49_R_ENVL) m_period[7:0]  = d;
            if (w && a == JT49_R_ENVH) m_period[15:8] = d;
            if (w && a == JT49_R_ENVSH) begin
                m_ctrl = d[3:0]; m_restart = 1'b1; m_psc = 0; m_steps = 0;
            end else if (fire) begin
                m_restart = 1'b0;
            end
        end
        cyc++;
        #1;
        check_output("ctrl", {28'b0, ctrl}, {28'b0, m_ctrl});
        check_output("restart", {31'b0, restart}, {31'b0, m_restart});
        check_output("period", {16'b0, period}, {16'b0, m_period});
`ifdef JT49_EG_READBACK_EN
        check_output("dout", {24'b0, dout}, {24'b0, m_dout});
`endif
    endtask

    // Idle cycles until a pulse; n counts cycles including the pulse cycle.
    task automatic run_until_eg(input int max_cycles, input bit c_gap, output int n);
        n = -1;
        for (int i = 1; i <= max_cycles; i++) begin
            apply_stimulus(1'b1, c_gap ? ((i % 4) == 0) : 1'b1, 1'b0, 4'h0, 8'h00);
            if (last_eg) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int pulses;
        bit prev_eg;
        logic [3:0] a;
        logic [7:0] d;

        vecs[0] = '{1'b1, 4'hB, 8'h34, 4'h0, 16'h0034, 1'b0};
        vecs[1] = '{1'b1, 4'hC, 8'h12, 4'h0, 16'h1234, 1'b0};
        vecs[2] = '{1'b1, 4'hD, 8'h5A, 4'hA, 16'h1234, 1'b1};
        vecs[3] = '{1'b1, 4'h7, 8'hFF, 4'hA, 16'h1234, 1'b1};
        vecs[4] = '{1'b0, 4'hB, 8'h99, 4'hA, 16'h1234, 1'b1};
        vecs[5] = '{1'b1, 4'hE, 8'h00, 4'hA, 16'h1234, 1'b1};
        vecs[6] = '{1'b1, 4'hB, 8'h00, 4'hA, 16'h1200, 1'b1};
        vecs[7] = '{1'b1, 4'hC, 8'h00, 4'hA, 16'h0000, 1'b1};
        vecs[8] = '{1'b1, 4'hD, 8'hF0, 4'h0, 16'h0000, 1'b1};

        apply_stimulus(1'b0, 1'b1, 1'b0, 4'h0, 8'h00);
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'h0, 8'h00);
        check_output("reset_ctrl", {28'b0, ctrl}, 32'h0);
        check_output("reset_restart", {31'b0, restart}, 32'h0);
        check_output("reset_period", {16'b0, period}, 32'h0);

        // Register writes with cen held low so no step interferes.
        foreach (vecs[i]) begin
            apply_stimulus(1'b1, 1'b0, vecs[i].we, vecs[i].addr, vecs[i].din);
            check_output($sformatf("vec%0d_ctrl", i), {28'b0, ctrl}, {28'b0, vecs[i].ctrl});
            check_output($sformatf("vec%0d_period", i), {16'b0, period}, {16'b0, vecs[i].period});
            check_output($sformatf("vec%0d_restart", i), {31'b0, restart}, {31'b0, vecs[i].restart});
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        check_output("reset_drops_restart", {31'b0, restart}, 32'h0);

        // Idle with period 0: one step per prescaler wrap.
        run_until_eg(100, 1'b0, n);
        check_output("idle_first", n, 16);
        run_until_eg(100, 1'b0, n);
        check_output("idle_interval", n, 16);
        check_output("idle_restart", {31'b0, restart}, 32'h0);

        // Period 3 then shape E: first step 48 cen ticks after the shape write.
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVL, 8'h03);
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVH, 8'h00);
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVSH, 8'h0E);
        check_output("shape_ctrl", {28'b0, ctrl}, 32'hE);
        check_output("shape_restart", {31'b0, restart}, 32'h1);
        run_until_eg(200, 1'b0, n);
        check_output("shape_first", n, 48);
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'h0, 8'h00);
        check_output("restart_consumed", {31'b0, restart}, 32'h0);
        run_until_eg(200, 1'b0, n);
        check_output("shape_interval", n, 47);

        // Lower the period below a count of 200: fires on the next tick.
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVL, 8'h00);
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVH, 8'h01);
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVSH, 8'h00);
        for (int i = 0; i < 5000 && m_steps != 200; i++)
            apply_stimulus(1'b1, 1'b1, 1'b0, 4'h0, 8'h00);
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVL, 8'h10);
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVH, 8'h00);
        check_output("lowered_period", {16'b0, period}, 32'h0010);
        run_until_eg(100, 1'b0, n);
        check_output("lowered_fire", n, 14);
        run_until_eg(400, 1'b0, n);
        check_output("lowered_interval", n, 256);

        // Shape write exactly when a step would fire suppresses it.
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVL, 8'h02);
        for (int i = 0; i < 200 && !predict_fire(1'b1, 1'b1, 1'b0, 4'h0); i++)
            apply_stimulus(1'b1, 1'b1, 1'b0, 4'h0, 8'h00);
        apply_stimulus(1'b1, 1'b1, 1'b1, JT49_R_ENVSH, 8'h03);
        check_output("collide_no_pulse", {31'b0, last_eg}, 32'h0);
        check_output("collide_restart", {31'b0, restart}, 32'h1);
        run_until_eg(200, 1'b0, n);
        check_output("collide_next", n, PRESCALE * 2);

        // cen 1-in-4: pulses only on cen cycles, never two in a row.
        pulses  = 0;
        prev_eg = 1'b0;
        for (int i = 0; i < 800; i++) begin
            apply_stimulus(1'b1, (i % 4) == 0, 1'b0, 4'h0, 8'h00);
            if (last_eg) begin
                pulses++;
                check_output("gated_on_cen", {31'b0, cen}, 32'h1);
                check_output("gated_width", {31'b0, prev_eg}, 32'h0);
            end
            prev_eg = last_eg;
        end
        check_output("gated_pulse_count_ok", {31'b0, (pulses >= 5 && pulses <= 7)}, 32'h1);

`ifdef JT49_EG_READBACK_EN
        apply_stimulus(1'b1, 1'b0, 1'b1, JT49_R_ENVH, 8'hA5);
        apply_stimulus(1'b1, 1'b0, 1'b1, JT49_R_ENVSH, 8'h0B);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'hC, 8'h00);
        check_output("rb_envh", {24'b0, dout}, 32'hA5);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'hD, 8'h00);
        check_output("rb_envsh", {24'b0, dout}, 32'h0B);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'h7, 8'h00);
        check_output("rb_other", {24'b0, dout}, 32'h00);
        apply_stimulus(1'b0, 1'b0, 1'b0, 4'hC, 8'h00);
        check_output("rb_reset", {24'b0, dout}, 32'h00);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'hC, 8'h00);
        check_output("rb_after_reset_c", {24'b0, dout}, 32'h00);
        apply_stimulus(1'b1, 1'b0, 1'b0, 4'hD, 8'h00);
        check_output("rb_after_reset_d", {24'b0, dout}, 32'h00);
`endif

        // Randomized traffic with short periods and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       a = JT49_R_ENVL;
                1:       a = JT49_R_ENVH;
                2:       a = JT49_R_ENVSH;
                default: a = 4'($urandom_range(0, 15));
            endcase
            d = 8'($urandom_range(0, 255));
            if (a == JT49_R_ENVL) d = 8'($urandom_range(0, 7));
            if (a == JT49_R_ENVH) d = 8'($urandom_range(0, 5) == 0);
            apply_stimulus($urandom_range(0, 199) != 0, $urandom_range(0, 2) != 0,
                           $urandom_range(0, 9) == 0, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
